// File: rtl/consumer.sv
// Dual-channel stream consumer: per-channel FIFOs with flush squash, a shared
// stall, and round-robin retirement onto one ready/valid output.
module consumer #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned ID_WIDTH      = 8,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDRESS_WIDTH-1:0] in_address_1,
    input  logic [ID_WIDTH-1:0]      in_id_1,
    input  logic                     in_valid_1,
    output logic                     out_stall_1,
    input  logic                     flush_1,
    input  logic [ID_WIDTH-1:0]      flush_id_1,
    input  logic [ADDRESS_WIDTH-1:0] in_address_2,
    input  logic [ID_WIDTH-1:0]      in_id_2,
    input  logic                     in_valid_2,
    output logic                     out_stall_2,
    input  logic                     flush_2,
    input  logic [ID_WIDTH-1:0]      flush_id_2,
    output logic                     ret_valid,
    input  logic                     ret_ready,
    output logic [ADDRESS_WIDTH-1:0] ret_address,
    output logic [ID_WIDTH-1:0]      ret_id,
    output logic                     ret_chan,
    output logic [CNT_WIDTH-1:0]     retired_count,
    output logic [CNT_WIDTH-1:0]     dropped_count
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [ADDRESS_WIDTH-1:0] r_addr     [2][FIFO_DEPTH];
    logic [ID_WIDTH-1:0]      r_id       [2][FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]    r_live     [2];
    logic [PW-1:0]            r_rd_ptr   [2];
    logic [PW-1:0]            r_wr_ptr   [2];
    logic [CW-1:0]            r_count    [2];
    logic                     r_rr;
    logic [CNT_WIDTH-1:0]     r_retired;
    logic [CNT_WIDTH-1:0]     r_dropped;

    logic [ADDRESS_WIDTH-1:0] w_in_addr  [2];
    logic [ID_WIDTH-1:0]      w_in_id    [2];
    logic                     w_in_valid [2];
    logic                     w_flush    [2];
    logic [ID_WIDTH-1:0]      w_flush_id [2];
    logic                     w_accept   [2];
    logic                     w_in_match [2];
    logic                     w_push     [2];
    logic                     w_pop      [2];
    logic                     w_elig     [2];
    logic [FIFO_DEPTH-1:0]    w_squash   [2];
    logic [FIFO_DEPTH-1:0]    w_live_d   [2];
    logic [CNT_WIDTH-1:0]     w_drop     [2];
    logic                     w_stall;
    logic                     w_grant;
    logic                     w_ret_valid;
    logic                     w_fire;

    assign w_in_addr  = '{in_address_1, in_address_2};
    assign w_in_id    = '{in_id_1, in_id_2};
    assign w_in_valid = '{in_valid_1, in_valid_2};
    assign w_flush    = '{flush_1, flush_2};
    assign w_flush_id = '{flush_id_1, flush_id_2};

    // Stall comes from registered occupancy only; a same-cycle pop never frees it.
    assign w_stall = (r_count[0] == CW'(FIFO_DEPTH)) || (r_count[1] == CW'(FIFO_DEPTH));

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            w_accept[c]   = w_in_valid[c] && !w_stall;
            w_in_match[c] = w_flush[c] && (w_in_id[c] == w_flush_id[c]);
            w_push[c]     = w_accept[c] && !w_in_match[c];
            w_elig[c]     = r_live[c][r_rd_ptr[c]] &&
                            !(w_flush[c] && (r_id[c][r_rd_ptr[c]] == w_flush_id[c]));
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                w_squash[c][i] = w_flush[c] && r_live[c][i] && (r_id[c][i] == w_flush_id[c]);
            end
        end
        w_grant     = w_elig[1] && (!w_elig[0] || r_rr);
        w_ret_valid = w_elig[0] || w_elig[1];
        w_fire      = w_ret_valid && ret_ready;
        for (int c = 0; c < 2; c++) begin
            // Dead heads drain unconditionally; live heads leave only when granted.
            w_pop[c] = ((r_count[c] != '0) && !r_live[c][r_rd_ptr[c]]) ||
                       (w_fire && (w_grant == 1'(c)));
            w_live_d[c] = r_live[c] & ~w_squash[c];
            if (w_pop[c]) w_live_d[c][r_rd_ptr[c]] = 1'b0;
            if (w_push[c]) w_live_d[c][r_wr_ptr[c]] = 1'b1;
            w_drop[c] = CNT_WIDTH'(w_accept[c] && w_in_match[c]);
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                w_drop[c] = w_drop[c] + CNT_WIDTH'(w_squash[c][i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int c = 0; c < 2; c++) begin
                for (int i = 0; i < FIFO_DEPTH; i++) begin
                    r_addr[c][i] <= '0;
                    r_id[c][i]   <= '0;
                end
                r_live[c]   <= '0;
                r_rd_ptr[c] <= '0;
                r_wr_ptr[c] <= '0;
                r_count[c]  <= '0;
            end
            r_rr      <= 1'b0;
            r_retired <= '0;
            r_dropped <= '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                r_live[c]  <= w_live_d[c];
                r_count[c] <= r_count[c] + CW'(w_push[c]) - CW'(w_pop[c]);
                if (w_pop[c]) r_rd_ptr[c] <= r_rd_ptr[c] + 1'b1;
                if (w_push[c]) begin
                    r_addr[c][r_wr_ptr[c]] <= w_in_addr[c];
                    r_id[c][r_wr_ptr[c]]   <= w_in_id[c];
                    r_wr_ptr[c]            <= r_wr_ptr[c] + 1'b1;
                end
            end
            if (w_fire) begin
                r_retired <= r_retired + 1'b1;
                r_rr      <= ~w_grant;
            end
            r_dropped <= r_dropped + w_drop[0] + w_drop[1];
        end
    end

    assign out_stall_1   = w_stall;
    assign out_stall_2   = w_stall;
    assign ret_valid     = w_ret_valid;
    assign ret_address   = w_ret_valid ? r_addr[w_grant][r_rd_ptr[w_grant]] : '0;
    assign ret_id        = w_ret_valid ? r_id[w_grant][r_rd_ptr[w_grant]] : '0;
    assign ret_chan      = w_ret_valid && w_grant;
    assign retired_count = r_retired;
    assign dropped_count = r_dropped;
endmodule

// File: tb/tb_consumer.sv
// Randomized plus directed bench for consumer, checked against a queue-based
// model of the two channel buffers.
module tb_consumer;
    localparam int AW = 32;
    localparam int IW = 8;
    localparam int D  = 4;
    localparam int CW = 16;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [IW-1:0] id;
        logic          live;
    } ent_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] d_addr [2];
    logic [IW-1:0] d_id   [2];
    logic          d_valid[2];
    logic          d_flush[2];
    logic [IW-1:0] d_fid  [2];
    logic          d_ready;
    logic [AW-1:0] s_addr [2];
    logic [IW-1:0] s_id   [2];
    logic          s_valid[2];
    logic          s_flush[2];
    logic [IW-1:0] s_fid  [2];
    logic          s_ready;

    logic          out_stall_1, out_stall_2, ret_valid, ret_chan;
    logic [AW-1:0] ret_address;
    logic [IW-1:0] ret_id;
    logic [CW-1:0] retired_count, dropped_count;

    ent_t          q[2][$];
    logic          m_rr;
    logic [CW-1:0] m_ret, m_drop;
    logic          m_last_stall;
    int            n_checks = 0;
    int            n_errors = 0;

    consumer #(.ADDRESS_WIDTH(AW), .ID_WIDTH(IW), .FIFO_DEPTH(D), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset),
        .in_address_1(d_addr[0]), .in_id_1(d_id[0]), .in_valid_1(d_valid[0]),
        .out_stall_1(out_stall_1), .flush_1(d_flush[0]), .flush_id_1(d_fid[0]),
        .in_address_2(d_addr[1]), .in_id_2(d_id[1]), .in_valid_2(d_valid[1]),
        .out_stall_2(out_stall_2), .flush_2(d_flush[1]), .flush_id_2(d_fid[1]),
        .ret_valid(ret_valid), .ret_ready(d_ready), .ret_address(ret_address),
        .ret_id(ret_id), .ret_chan(ret_chan),
        .retired_count(retired_count), .dropped_count(dropped_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        q[0].delete();
        q[1].delete();
        m_rr = 1'b0;
        m_ret = '0;
        m_drop = '0;
        m_last_stall = 1'b0;
    endtask

    task automatic idle_inputs();
        for (int c = 0; c < 2; c++) begin
            s_addr[c] = '0; s_id[c] = '0; s_valid[c] = 1'b0;
            s_flush[c] = 1'b0; s_fid[c] = '0;
        end
        s_ready = 1'b0;
    endtask

    // One clock: apply staged inputs, compare outputs against the model, advance the model.
    task automatic run_cycle();
        logic stall, rv, fire;
        logic elig[2];
        int   gnt;
        ent_t e;
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            d_addr[c] = s_addr[c]; d_id[c] = s_id[c]; d_valid[c] = s_valid[c];
            d_flush[c] = s_flush[c]; d_fid[c] = s_fid[c];
        end
        d_ready = s_ready;
        #1;
        stall = (q[0].size() == D) || (q[1].size() == D);
        for (int c = 0; c < 2; c++)
            elig[c] = (q[c].size() > 0) && q[c][0].live &&
                      !(s_flush[c] && q[c][0].id == s_fid[c]);
        gnt = (elig[0] && elig[1]) ? int'(m_rr) : (elig[1] ? 1 : 0);
        rv  = elig[0] || elig[1];
        check_eq("stall_1", 32'(out_stall_1), 32'(stall));
        check_eq("stall_2", 32'(out_stall_2), 32'(stall));
        check_eq("ret_valid", 32'(ret_valid), 32'(rv));
        if (rv) begin
            check_eq("ret_id", 32'(ret_id), 32'(q[gnt][0].id));
            check_eq("ret_address", ret_address, q[gnt][0].addr);
            check_eq("ret_chan", 32'(ret_chan), 32'(gnt));
        end else if (q[0].size() == 0 && q[1].size() == 0) begin
            check_eq("empty_id", 32'(ret_id), 32'd0);
            check_eq("empty_address", ret_address, 32'd0);
            check_eq("empty_chan", 32'(ret_chan), 32'd0);
        end
        check_eq("retired_count", 32'(retired_count), 32'(m_ret));
        check_eq("dropped_count", 32'(dropped_count), 32'(m_drop));
        fire = rv && s_ready;
        for (int c = 0; c < 2; c++) begin
            if (q[c].size() > 0 && !q[c][0].live) void'(q[c].pop_front());
            else if (fire && gnt == c) void'(q[c].pop_front());
            for (int i = 0; i < q[c].size(); i++) begin
                e = q[c][i];
                if (s_flush[c] && e.live && e.id == s_fid[c]) begin
                    e.live = 1'b0;
                    q[c][i] = e;
                    m_drop = m_drop + 1'b1;
                end
            end
            if (s_valid[c] && !stall) begin
                if (s_flush[c] && s_id[c] == s_fid[c]) m_drop = m_drop + 1'b1;
                else q[c].push_back('{addr: s_addr[c], id: s_id[c], live: 1'b1});
            end
        end
        if (fire) begin
            m_ret = m_ret + 1'b1;
            m_rr  = (gnt == 0);
        end
        m_last_stall = stall;
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        d_valid[0] = 1'b1; d_valid[1] = 1'b1;
        d_ready = 1'b1;
        @(posedge clk);
        model_clear();
        #1;
        check_eq("rst_ret_valid", 32'(ret_valid), 32'd0);
        check_eq("rst_stall", 32'({out_stall_1, out_stall_2}), 32'd0);
        check_eq("rst_retired", 32'(retired_count), 32'd0);
        check_eq("rst_dropped", 32'(dropped_count), 32'd0);
    endtask

    task automatic beat(input int c, input logic [AW-1:0] a, input logic [IW-1:0] id,
                        input logic rdy);
        idle_inputs();
        s_valid[c] = 1'b1; s_addr[c] = a; s_id[c] = id; s_ready = rdy;
        run_cycle();
    endtask

    initial begin
        int  k;
        logic hold[2];
        idle_inputs();
        for (int c = 0; c < 2; c++) begin
            d_addr[c] = '0; d_id[c] = '0; d_valid[c] = 1'b0; d_flush[c] = 1'b0; d_fid[c] = '0;
        end
        d_ready = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_eq("init_ret_valid", 32'(ret_valid), 32'd0);
        check_eq("init_stall", 32'({out_stall_1, out_stall_2}), 32'd0);
        check_eq("init_counts", 32'({retired_count, dropped_count}), 32'd0);

        // In-order retirement on channel 1 only.
        beat(0, 32'h4, 8'h11, 1'b1);
        beat(0, 32'h8, 8'h12, 1'b1);
        beat(0, 32'hC, 8'h13, 1'b1);
        idle_inputs(); s_ready = 1'b1;
        run_cycle(); run_cycle();
        #1 check_eq("plan1_retired", 32'(retired_count), 32'd3);

        // Fill to stall, hold beat 5, then release.
        k = 1;
        for (int cyc = 0; cyc < 14; cyc++) begin
            idle_inputs();
            s_valid[0] = (k <= 5); s_id[0] = 8'h10 + 8'(k); s_addr[0] = 32'(k * 4);
            s_ready = (cyc >= 7);
            run_cycle();
            if (s_valid[0] && !m_last_stall) k++;
        end
        check_eq("plan2_accepts", 32'(k), 32'd6);

        // Both channels full, alternating retirement.
        for (int i = 0; i < D; i++) begin
            idle_inputs();
            s_valid[0] = 1'b1; s_id[0] = 8'h10 + 8'(i); s_addr[0] = 32'h100 + 32'(i);
            s_valid[1] = 1'b1; s_id[1] = 8'h20 + 8'(i); s_addr[1] = 32'h200 + 32'(i);
            run_cycle();
        end
        idle_inputs(); s_ready = 1'b1;
        repeat (2 * D + 2) run_cycle();

        // Flush of a resident entry, then of a same-edge incoming beat.
        do_reset();
        for (int i = 0; i < D; i++) beat(0, 32'h40 + 32'(i), 8'h12 + 8'(i), 1'b0);
        idle_inputs(); s_flush[0] = 1'b1; s_fid[0] = 8'h14;
        run_cycle();
        #1 check_eq("plan4_dropped", 32'(dropped_count), 32'd1);
        idle_inputs(); s_ready = 1'b1;
        repeat (6) run_cycle();
        idle_inputs(); s_valid[0] = 1'b1; s_id[0] = 8'h16; s_addr[0] = 32'h58;
        s_flush[0] = 1'b1; s_fid[0] = 8'h16; s_ready = 1'b1;
        run_cycle();
        #1 check_eq("plan5_dropped", 32'(dropped_count), 32'd2);
        check_eq("plan5_not_written", 32'(ret_valid), 32'd0);

        // Reset with both FIFOs partially full.
        for (int i = 0; i < 2; i++) begin
            idle_inputs();
            s_valid[0] = 1'b1; s_id[0] = 8'h17 + 8'(i); s_addr[0] = 32'h60 + 32'(i);
            s_valid[1] = 1'b1; s_id[1] = 8'h27 + 8'(i); s_addr[1] = 32'h70 + 32'(i);
            run_cycle();
        end
        do_reset();
        beat(1, 32'h99, 8'h2A, 1'b1);
        idle_inputs(); s_ready = 1'b1;
        run_cycle();

        // Randomized traffic with flushes, backpressure and occasional reset.
        hold[0] = 1'b0; hold[1] = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < 2; c++) begin
                if (!hold[c]) begin
                    s_valid[c] = ($urandom_range(0, 3) != 0);
                    s_addr[c]  = $urandom;
                    s_id[c]    = {4'(c + 1), 4'($urandom_range(0, 7))};
                end
                s_flush[c] = ($urandom_range(0, 5) == 0);
                s_fid[c]   = {4'(c + 1), 4'($urandom_range(0, 7))};
            end
            s_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
                hold[0] = 1'b0; hold[1] = 1'b0;
            end else begin
                run_cycle();
                for (int c = 0; c < 2; c++) hold[c] = s_valid[c] && m_last_stall;
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
